mc_controller: RTL and testbench

Multicycle sequencing controller for the ARM core. It replaces the single-cycle `controller` so that one unified memory and one ALU can serve instruction fetch, address generation and PC increment. The block decodes the instruction register field and steps through a Moore FSM, which drives every datapath select and enable. It also holds the NZCV flags and applies ARM condition gating to architectural writes.

---
 rtl/mc_controller.sv | 183 ++++++++++++++++++
 tb/tb_mc_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM sequencing controller: Moore FSM driving datapath selects/enables,
// with an NZCV flags register and condition-gated architectural writes.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  state_t      state, next_state;
  logic [3:0]  flags;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [2:0]  dp_op;
  logic        no_write, cond_ex;
  logic        pcw, memw, irw, regw;
  logic        unused_bits;

  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign rd          = Instr[3:0];
  assign unused_bits = ^Instr[11:4];

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = !z;
      4'b0010: cond_check = cy;
      4'b0011: cond_check = !cy;
      4'b0100: cond_check = n;
      4'b0101: cond_check = !n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = !v;
      4'b1000: cond_check = cy & !z;
      4'b1001: cond_check = !cy | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = !z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Gating always uses the registered flags, never the live ALU flags.
  assign cond_ex = cond_check(cond, flags);

  always_comb begin
    dp_op    = ALU_ADD;
    no_write = 1'b0;
    case (funct[4:1])
      4'b0100: dp_op = ALU_ADD;
      4'b0010: dp_op = ALU_SUB;
      4'b0000: dp_op = ALU_AND;
      4'b1100: dp_op = ALU_ORR;
      4'b1010: begin dp_op = ALU_SUB; no_write = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= next_state;
      if ((state == EXECR || state == EXECI) && funct[0] && cond_ex) begin
        flags[3:2] <= ALUFlags[3:2];
        if (dp_op == ALU_ADD || dp_op == ALU_SUB)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = FETCH;
    pcw        = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        next_state = DECODE;
        irw        = 1'b1;
        pcw        = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   next_state = funct[5] ? EXECI : EXECR;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: begin
        next_state = funct[0] ? MEMRD : MEMWR;
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      MEMRD: begin
        next_state = MEMWB;
        AdrSrc     = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        if (rd == 4'hF) pcw = cond_ex;
        else            regw = cond_ex;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memw   = cond_ex;
      end
      EXECR: begin
        next_state = ALUWB;
        ALUControl = dp_op;
      end
      EXECI: begin
        next_state = ALUWB;
        ALUSrcB    = 2'b01;
        ALUControl = dp_op;
      end
      ALUWB: begin
        if (!no_write) begin
          if (rd == 4'hF) pcw = cond_ex;
          else            regw = cond_ex;
        end
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = cond_ex;
      end
      default: next_state = FETCH;
    endcase
  end

  // A low reset suppresses every architectural write in the same cycle.
  assign PCWrite  = pcw  & reset;
  assign MemWrite = memw & reset;
  assign IRWrite  = irw  & reset;
  assign RegWrite = regw & reset;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign State    = state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle vector table checked through a scoreboard queue,
// followed by instruction latency sequences.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [19:0] i;
    logic [3:0]  fl;
    logic [16:0] e;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] sbq[$];
  int          tests = 0;
  int          fails = 0;

  localparam logic [19:0] I_ADD   = 20'hE0821, I_LDR   = 20'hE5921, I_STR  = 20'hE5821;
  localparam logic [19:0] I_LDRM  = 20'hE5121, I_SUBS  = 20'hE0500, I_ADDNE = 20'h10821;
  localparam logic [19:0] I_BEQ   = 20'h0A000, I_BNE   = 20'h1A000, I_CMP  = 20'hE1500;
  localparam logic [19:0] I_BMI   = 20'h4A000, I_BPL   = 20'h5A000, I_ANDS = 20'hE0100;
  localparam logic [19:0] I_BCS   = 20'h2A000, I_BVS   = 20'h6A000, I_ORRI = 20'hE3821;
  localparam logic [19:0] I_MOV   = 20'hE1A21, I_ADDPC = 20'hE082F, I_LDRPC = 20'hE592F;
  localparam logic [19:0] I_UND   = 20'hEC000, I_BCC   = 20'h3A000;

  // Expected bundle: {State, PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
  function automatic logic [16:0] ex(input int st, input bit pcw, input bit memw, input bit irw,
                                     input bit regw, input bit adr, input int res, input bit sa,
                                     input int sbv, input int alu);
    logic [3:0] s4;
    logic [1:0] r2, b2;
    logic [2:0] a3;
    s4 = st[3:0]; r2 = res[1:0]; b2 = sbv[1:0]; a3 = alu[2:0];
    return {s4, pcw, memw, irw, regw, adr, r2, sa, b2, a3};
  endfunction

  function automatic vec_t mk(input logic r, input logic [19:0] i, input logic [3:0] fl,
                              input logic [16:0] e);
    vec_t v;
    v.r = r; v.i = i; v.fl = fl; v.e = e;
    return v;
  endfunction

  function automatic vec_t fe(input logic [19:0] i);
    return mk(1'b1, i, 4'h0, ex(0, 1, 0, 1, 0, 0, 2, 1, 2, 0));
  endfunction

  function automatic vec_t de(input logic [19:0] i);
    return mk(1'b1, i, 4'h0, ex(1, 0, 0, 0, 0, 0, 2, 1, 2, 0));
  endfunction

  function automatic vec_t br(input logic [19:0] i, input bit taken);
    return mk(1'b1, i, 4'h0, ex(9, taken, 0, 0, 0, 0, 2, 0, 1, 0));
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic run_lat(input logic [19:0] ins, input int exp_cyc, input string nm);
    int n;
    Instr = ins;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (State != 4'd0 && n < 20);
    tests++;
    if (n != exp_cyc) begin
      fails++;
      $display("FAIL latency_%s actual=%0d required=%0d", nm, n, exp_cyc);
    end
  endtask

  initial begin
    // reset state, then each instruction cycle by cycle
    vecs.push_back(mk(1'b0, I_ADD, 4'h0, ex(0, 0, 0, 0, 0, 0, 2, 1, 2, 0)));
    vecs.push_back(fe(I_ADD)); vecs.push_back(de(I_ADD));
    vecs.push_back(mk(1, I_ADD, 0, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_ADD, 0, ex(8, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_LDR)); vecs.push_back(de(I_LDR));
    vecs.push_back(mk(1, I_LDR, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(1, I_LDR, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_LDR, 0, ex(4, 0, 0, 0, 1, 0, 1, 0, 0, 0)));
    vecs.push_back(fe(I_STR)); vecs.push_back(de(I_STR));
    vecs.push_back(mk(1, I_STR, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(1, I_STR, 0, ex(5, 0, 1, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(fe(I_LDRM)); vecs.push_back(de(I_LDRM));
    vecs.push_back(mk(1, I_LDRM, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
    vecs.push_back(mk(1, I_LDRM, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_LDRM, 0, ex(4, 0, 0, 0, 1, 0, 1, 0, 0, 0)));
    vecs.push_back(fe(I_SUBS)); vecs.push_back(de(I_SUBS));
    vecs.push_back(mk(1, I_SUBS, 4'b0100, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(1, I_SUBS, 0, ex(8, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_ADDNE)); vecs.push_back(de(I_ADDNE));
    vecs.push_back(mk(1, I_ADDNE, 0, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_ADDNE, 0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_BEQ)); vecs.push_back(de(I_BEQ)); vecs.push_back(br(I_BEQ, 1));
    vecs.push_back(fe(I_BNE)); vecs.push_back(de(I_BNE)); vecs.push_back(br(I_BNE, 0));
    vecs.push_back(fe(I_CMP)); vecs.push_back(de(I_CMP));
    vecs.push_back(mk(1, I_CMP, 4'b1000, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(1, I_CMP, 0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_BMI)); vecs.push_back(de(I_BMI)); vecs.push_back(br(I_BMI, 1));
    vecs.push_back(fe(I_BPL)); vecs.push_back(de(I_BPL)); vecs.push_back(br(I_BPL, 0));
    vecs.push_back(fe(I_ANDS)); vecs.push_back(de(I_ANDS));
    vecs.push_back(mk(1, I_ANDS, 4'b0111, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
    vecs.push_back(mk(1, I_ANDS, 0, ex(8, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_BEQ)); vecs.push_back(de(I_BEQ)); vecs.push_back(br(I_BEQ, 1));
    vecs.push_back(fe(I_BCS)); vecs.push_back(de(I_BCS)); vecs.push_back(br(I_BCS, 0));
    vecs.push_back(fe(I_BVS)); vecs.push_back(de(I_BVS)); vecs.push_back(br(I_BVS, 0));
    vecs.push_back(fe(I_ORRI)); vecs.push_back(de(I_ORRI));
    vecs.push_back(mk(1, I_ORRI, 0, ex(7, 0, 0, 0, 0, 0, 0, 0, 1, 3)));
    vecs.push_back(mk(1, I_ORRI, 0, ex(8, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_MOV)); vecs.push_back(de(I_MOV));
    vecs.push_back(mk(1, I_MOV, 0, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_MOV, 0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_ADDPC)); vecs.push_back(de(I_ADDPC));
    vecs.push_back(mk(1, I_ADDPC, 0, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_ADDPC, 0, ex(8, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(fe(I_LDRPC)); vecs.push_back(de(I_LDRPC));
    vecs.push_back(mk(1, I_LDRPC, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(1, I_LDRPC, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, I_LDRPC, 0, ex(4, 1, 0, 0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(fe(I_UND)); vecs.push_back(de(I_UND));
    // STR aborted by reset in MEMWR, reset held three more cycles, then flags observed cleared
    vecs.push_back(fe(I_STR)); vecs.push_back(de(I_STR));
    vecs.push_back(mk(1, I_STR, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(0, I_STR, 0, ex(5, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, I_STR, 0, ex(0, 0, 0, 0, 0, 0, 2, 1, 2, 0)));
    vecs.push_back(fe(I_BEQ)); vecs.push_back(de(I_BEQ)); vecs.push_back(br(I_BEQ, 0));
    vecs.push_back(fe(I_BCC)); vecs.push_back(de(I_BCC)); vecs.push_back(br(I_BCC, 1));

    reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      logic [16:0] act, req;
      logic [1:0]  op;
      @(posedge clk); #1;
      reset    = vecs[k].r;
      Instr    = vecs[k].i;
      ALUFlags = vecs[k].fl;
      sbq.push_back(vecs[k].e);
      @(negedge clk);
      act = {State, PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl};
      req = sbq.pop_front();
      check($sformatf("row%0d_outputs", k), act, req);
      op = vecs[k].i[15:14];
      if (k % 8 == 0) begin
        check($sformatf("row%0d_immsrc", k), {15'd0, ImmSrc}, {15'd0, op});
        check($sformatf("row%0d_regsrc", k), {15'd0, RegSrc},
              {15'd0, op == 2'b01, op == 2'b10});
      end
    end

    ALUFlags = 4'h0;
    @(posedge clk); #1;
    run_lat(I_LDR, 5, "ldr");
    run_lat(I_STR, 4, "str");
    run_lat(I_ADD, 4, "dp");
    run_lat(I_ORRI, 4, "dp_imm");
    run_lat(I_BCC, 3, "branch");
    run_lat(I_UND, 2, "undef");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
